result_skid16: RTL and testbench
================================

# result_skid16

Registered two-entry skid buffer between the 16-bit bitwise/ALU logic stage (Or16, And16, Not16 network) and its consumer: register file, D/A load path or memory write. It captures each 16-bit combinational result under a valid/ready handshake and presents it registered to the downstream stage. It sustains one transfer per cycle with no combinational path from OUT_READY to IN_READY. Optionally it carries Hack-style ZR/NG status flags alongside each word.

## Interface
- WIDTH, 16: data word width; flags and compare logic scale with it.
- CLK  input  1  single clock; all state updates on rising edge.
- RST_N  input  1  asynchronous, active-low reset; asserts immediately, deassertion synchronous to CLK by the system.
- IN  input  WIDTH  result word from the upstream logic stage.
- IN_VALID  input  1  IN holds a word to transfer.
- IN_READY  output  1  buffer can accept; registered.
- OUT  output  WIDTH  buffered word, driven from the main register.
- OUT_VALID  output  1  OUT holds a word; registered.
- OUT_READY  input  1  consumer accepts OUT this cycle.
- ZR  output  1  OUT == 0 (present only with RESULT_SKID16_FLAGS_EN).
- NG  output  1  OUT[WIDTH-1] (present only with RESULT_SKID16_FLAGS_EN).
- LEVEL  output  2  entries held: 0, 1 or 2.

## Operation
- Accept: IN_VALID && IN_READY. Release: OUT_VALID && OUT_READY.
- Storage: main register (drives OUT) and skid register; each holds a word plus flags.
- States: EMPTY (LEVEL 0), ONE (main full), TWO (main and skid full).
- EMPTY: accept -> word to main, go ONE; else stay.
- ONE: accept and release -> new word to main, stay ONE. Accept only -> word to skid, go TWO. Release only -> go EMPTY. Neither -> hold.
- TWO: IN_READY=0, input ignored. Release -> skid moves to main, go ONE. No release -> hold both.
- IN_VALID without IN_READY: no state change; upstream holds IN stable (not checked).
- OUT_READY while OUT_VALID=0: ignored.
- Data order strictly FIFO; no word dropped or duplicated.
- Flags computed on IN at accept and stored per entry, never recomputed from OUT.

## Timing
- Reset values: OUT_VALID=0, IN_READY=1, OUT=0, ZR=1, NG=0, LEVEL=0, skid cleared.
- Reset mid-operation: both entries discarded immediately (asynchronously). First accept permitted on the first rising edge after deassertion.
- Latency: word accepted at edge N is on OUT with OUT_VALID=1 after edge N.
- Throughput: 1 word/cycle with OUT_READY held high. State stays ONE.
- IN_READY = !(state==TWO), registered. It drops the cycle after the skid fills and rises the cycle after a release from TWO.
- OUT_READY is not combinationally connected to IN_READY.

## Configuration
- RESULT_SKID16_FLAGS_EN defined: each entry stores ZR (IN==0) and NG (IN[WIDTH-1]), and the ZR/NG ports exist and track OUT. Entry width is WIDTH+2.
- Undefined: no ZR/NG ports or flag storage. Entry width is WIDTH. Behaviour is otherwise identical.

## Structure
- Shared package: state encoding (ST_EMPTY=0, ST_ONE=1, ST_TWO=2) and entry-width constant derived from WIDTH and the macro.
- Sub-module: result_flags16, a combinational ZR/NG generator on IN. It is instantiated only under the macro.
- Top module holds the state register, both entry registers and the handshake logic.

## Test plan
- Reset with IN_VALID=1, IN=16'h1234 -> OUT_VALID=0, IN_READY=1, LEVEL=0, OUT=0 until first edge after RST_N rises. Then OUT=16'h1234 one cycle later.
- Stream 16'h0001..16'h0010 with OUT_READY=1 -> 16 words out in order, one per cycle, 1-cycle latency, LEVEL stays 1, IN_READY never low.
- OUT_READY=0, push 16'hAAAA, 16'h5555, 16'hFFFF -> LEVEL=2, IN_READY=0 after second accept, 16'hFFFF held upstream. OUT_READY=1 -> AAAA, 5555, FFFF in order.
- Random IN_VALID/OUT_READY 50% each, 1000 words -> scoreboard exact FIFO match, LEVEL never >2, IN_READY==(LEVEL!=2) every cycle.
- Flags build: push 16'h0000, 16'h8001, 16'h7FFF -> (ZR,NG) = (1,0), (0,1), (0,0) aligned with each OUT word, including through skid.
- Assert RST_N low with LEVEL=2 -> OUT_VALID=0, LEVEL=0 immediately. No stale word appears after reset release.

Source files
------------

// File: rtl/result_skid16_pkg.sv
// Shared types and sizing for the result_skid16 buffer.
// Setting RESULT_SKID16_FLAGS_EN widens each entry with ZR/NG status bits.
package result_skid16_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

`ifdef RESULT_SKID16_FLAGS_EN
  localparam int unsigned FLAG_W = 2;
`else
  localparam int unsigned FLAG_W = 0;
`endif

  function automatic int unsigned entry_w(input int unsigned width);
    return width + FLAG_W;
  endfunction

endpackage

// File: rtl/result_skid16_if.sv
// Valid/ready handshake bundle for result_skid16: upstream word in, buffered word out.
interface result_skid16_if #(
  parameter int unsigned WIDTH = 16
) ();

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/result_skid16_flags.sv
// Combinational Hack-style status generator: ZR when the word is zero, NG from its sign bit.
module result_flags16 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_data,
  output logic             o_zr,
  output logic             o_ng
);

  assign o_zr = (i_data == '0);
  assign o_ng = i_data[WIDTH-1];

endmodule

// File: rtl/result_skid16.sv
// Two-entry registered skid buffer for ALU results; all outputs come straight from flops.
// Define RESULT_SKID16_FLAGS_EN to store ZR/NG with each entry and expose o_zr/o_ng.
module result_skid16
  import result_skid16_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  result_skid16_if.slave       io_bus,
`ifdef RESULT_SKID16_FLAGS_EN
  output logic                 o_zr,
  output logic                 o_ng,
`endif
  output logic [1:0]           o_level
);

  localparam int unsigned EntryW = entry_w(WIDTH);

  state_e            r_state;
  logic [EntryW-1:0] r_main;
  logic [EntryW-1:0] r_skid;
  logic              r_in_ready;
  logic              r_out_valid;

  logic [EntryW-1:0] w_in_entry;
  logic [EntryW-1:0] w_rst_entry;
  logic              w_accept;
  logic              w_release;

`ifdef RESULT_SKID16_FLAGS_EN
  logic w_zr;
  logic w_ng;

  // Flags are taken from IN at accept time and travel with the word.
  result_flags16 #(
    .WIDTH (WIDTH)
  ) u_flags (
    .i_data (io_bus.in_data),
    .o_zr   (w_zr),
    .o_ng   (w_ng)
  );

  assign w_in_entry  = {w_zr, w_ng, io_bus.in_data};
  assign w_rst_entry = {1'b1, 1'b0, {WIDTH{1'b0}}};
  assign o_zr        = r_main[WIDTH+1];
  assign o_ng        = r_main[WIDTH];
`else
  assign w_in_entry  = io_bus.in_data;
  assign w_rst_entry = '0;
`endif

  assign w_accept  = io_bus.in_valid & r_in_ready;
  assign w_release = r_out_valid & io_bus.out_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_EMPTY;
      r_main      <= w_rst_entry;
      r_skid      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_main      <= w_in_entry;
            r_out_valid <= 1'b1;
            r_state     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_accept && w_release) begin
            r_main <= w_in_entry;
          end else if (w_accept) begin
            r_skid     <= w_in_entry;
            r_in_ready <= 1'b0;
            r_state    <= ST_TWO;
          end else if (w_release) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_release) begin
            r_main     <= r_skid;
            r_in_ready <= 1'b1;
            r_state    <= ST_ONE;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign io_bus.in_ready  = r_in_ready;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.out_data  = r_main[WIDTH-1:0];
  assign o_level          = r_state;

endmodule

// File: tb/tb_result_skid16.sv
// Directed and randomised bench for result_skid16; flag checks compile in with RESULT_SKID16_FLAGS_EN.
module tb_result_skid16;

  logic       clk;
  logic       rst_n;
  logic [1:0] level;
`ifdef RESULT_SKID16_FLAGS_EN
  logic       zr;
  logic       ng;
`endif

  int errors = 0;
  int checks = 0;

  result_skid16_if #(.WIDTH(16)) u_if ();

  result_skid16 #(
    .WIDTH (16)
  ) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (u_if.slave),
`ifdef RESULT_SKID16_FLAGS_EN
    .o_zr    (zr),
    .o_ng    (ng),
`endif
    .o_level (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    u_if.in_valid = 1'b1;
    u_if.in_data = 16'h1234;
    u_if.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (u_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", u_if.out_valid); end
      checks++; if (u_if.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", u_if.in_ready); end
      checks++; if (level !== 2'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
      checks++; if (u_if.out_data !== 16'h0000) begin errors++; $display("FAIL reset_out got=%h exp=0000", u_if.out_data); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (u_if.out_valid !== 1'b0) begin errors++; $display("FAIL post_release_valid got=%b exp=0", u_if.out_valid); end
    tick();
    checks++; if (u_if.out_valid !== 1'b1) begin errors++; $display("FAIL first_accept_valid got=%b exp=1", u_if.out_valid); end
    checks++; if (u_if.out_data !== 16'h1234) begin errors++; $display("FAIL first_accept_out got=%h exp=1234", u_if.out_data); end
    checks++; if (level !== 2'd1) begin errors++; $display("FAIL first_accept_level got=%0d exp=1", level); end
    u_if.in_valid = 1'b0;
    u_if.out_ready = 1'b1;
    tick();
    checks++; if (level !== 2'd0) begin errors++; $display("FAIL drain_level got=%0d exp=0", level); end
    u_if.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] w;
    for (int i = 1; i <= 16; i++) begin
      w = 16'(i);
      u_if.in_data = w;
      u_if.in_valid = 1'b1;
      u_if.out_ready = 1'b1;
      tick();
      checks++; if (u_if.out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, u_if.out_valid); end
      checks++; if (u_if.out_data !== w) begin errors++; $display("FAIL stream_out[%0d] got=%h exp=%h", i, u_if.out_data, w); end
      checks++; if (level !== 2'd1) begin errors++; $display("FAIL stream_level[%0d] got=%0d exp=1", i, level); end
      checks++; if (u_if.in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d] got=%b exp=1", i, u_if.in_ready); end
    end
    u_if.in_valid = 1'b0;
    tick();
    checks++; if (level !== 2'd0) begin errors++; $display("FAIL stream_end_level got=%0d exp=0", level); end
    u_if.out_ready = 1'b0;
  endtask

  task automatic test_skid();
    u_if.out_ready = 1'b0;
    u_if.in_valid = 1'b1;
    u_if.in_data = 16'hAAAA;
    tick();
    checks++; if (level !== 2'd1) begin errors++; $display("FAIL skid_level1 got=%0d exp=1", level); end
    checks++; if (u_if.in_ready !== 1'b1) begin errors++; $display("FAIL skid_ready1 got=%b exp=1", u_if.in_ready); end
    u_if.in_data = 16'h5555;
    tick();
    checks++; if (level !== 2'd2) begin errors++; $display("FAIL skid_level2 got=%0d exp=2", level); end
    checks++; if (u_if.in_ready !== 1'b0) begin errors++; $display("FAIL skid_ready2 got=%b exp=0", u_if.in_ready); end
    checks++; if (u_if.out_data !== 16'hAAAA) begin errors++; $display("FAIL skid_out_hold got=%h exp=aaaa", u_if.out_data); end
    u_if.in_data = 16'hFFFF;
    tick();
    checks++; if (level !== 2'd2) begin errors++; $display("FAIL skid_full_hold got=%0d exp=2", level); end
    checks++; if (u_if.out_data !== 16'hAAAA) begin errors++; $display("FAIL skid_full_out got=%h exp=aaaa", u_if.out_data); end
    u_if.out_ready = 1'b1;
    tick();
    checks++; if (u_if.out_data !== 16'h5555) begin errors++; $display("FAIL skid_second got=%h exp=5555", u_if.out_data); end
    checks++; if (level !== 2'd1) begin errors++; $display("FAIL skid_after_release got=%0d exp=1", level); end
    checks++; if (u_if.in_ready !== 1'b1) begin errors++; $display("FAIL skid_ready_back got=%b exp=1", u_if.in_ready); end
    tick();
    checks++; if (u_if.out_data !== 16'hFFFF) begin errors++; $display("FAIL skid_third got=%h exp=ffff", u_if.out_data); end
    u_if.in_valid = 1'b0;
    tick();
    checks++; if (level !== 2'd0) begin errors++; $display("FAIL skid_drained got=%0d exp=0", level); end
    checks++; if (u_if.out_valid !== 1'b0) begin errors++; $display("FAIL skid_drained_valid got=%b exp=0", u_if.out_valid); end
    u_if.out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [15:0] q[$];
    logic [15:0] exp_w;
    int sent = 0;
    int got = 0;
    int cyc = 0;
    bit acc;
    bit rel;
    while (got < 1000 && cyc < 20000) begin
      u_if.in_valid = (sent < 1000) && ($urandom_range(0, 1) == 1);
      u_if.in_data = 16'($urandom);
      u_if.out_ready = ($urandom_range(0, 1) == 1);
      acc = u_if.in_valid && u_if.in_ready;
      rel = u_if.out_valid && u_if.out_ready;
      if (rel) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rand_spurious got=%h exp=none", u_if.out_data);
        end else begin
          exp_w = q.pop_front();
          if (u_if.out_data !== exp_w) begin
            errors++; $display("FAIL rand_data[%0d] got=%h exp=%h", got, u_if.out_data, exp_w);
          end
          got++;
        end
      end
      if (acc) begin
        q.push_back(u_if.in_data);
        sent++;
      end
      tick();
      cyc++;
      checks++; if (32'(level) !== q.size()) begin errors++; $display("FAIL rand_level got=%0d exp=%0d", level, q.size()); end
      checks++; if (u_if.in_ready !== (q.size() != 2)) begin errors++; $display("FAIL rand_in_ready got=%b exp=%b", u_if.in_ready, q.size() != 2); end
      checks++; if (u_if.out_valid !== (q.size() != 0)) begin errors++; $display("FAIL rand_out_valid got=%b exp=%b", u_if.out_valid, q.size() != 0); end
    end
    checks++; if (got != 1000) begin errors++; $display("FAIL rand_timeout got=%0d exp=1000", got); end
    u_if.in_valid = 1'b0;
    u_if.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    u_if.out_ready = 1'b0;
    u_if.in_valid = 1'b1;
    u_if.in_data = 16'h1111;
    tick();
    u_if.in_data = 16'h2222;
    tick();
    checks++; if (level !== 2'd2) begin errors++; $display("FAIL mid_pre_level got=%0d exp=2", level); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (u_if.out_valid !== 1'b0) begin errors++; $display("FAIL mid_async_valid got=%b exp=0", u_if.out_valid); end
    checks++; if (level !== 2'd0) begin errors++; $display("FAIL mid_async_level got=%0d exp=0", level); end
    checks++; if (u_if.in_ready !== 1'b1) begin errors++; $display("FAIL mid_async_ready got=%b exp=1", u_if.in_ready); end
    u_if.in_valid = 1'b0;
    u_if.out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (u_if.out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale_valid got=%b exp=0", u_if.out_valid); end
    checks++; if (level !== 2'd0) begin errors++; $display("FAIL mid_stale_level got=%0d exp=0", level); end
    u_if.out_ready = 1'b0;
    u_if.in_valid = 1'b1;
    u_if.in_data = 16'h0BEE;
    tick();
    checks++; if (u_if.out_data !== 16'h0BEE) begin errors++; $display("FAIL mid_restart_out got=%h exp=0bee", u_if.out_data); end
    u_if.in_valid = 1'b0;
    u_if.out_ready = 1'b1;
    tick();
    u_if.out_ready = 1'b0;
  endtask

`ifdef RESULT_SKID16_FLAGS_EN
  task automatic test_flags();
    u_if.out_ready = 1'b0;
    u_if.in_valid = 1'b1;
    u_if.in_data = 16'h0000;
    tick();
    checks++; if ({zr, ng} !== 2'b10) begin errors++; $display("FAIL flags_0000 got=%b%b exp=10", zr, ng); end
    u_if.in_data = 16'h8001;
    tick();
    checks++; if ({zr, ng} !== 2'b10) begin errors++; $display("FAIL flags_hold got=%b%b exp=10", zr, ng); end
    u_if.in_data = 16'h7FFF;
    u_if.out_ready = 1'b1;
    tick();
    checks++; if (u_if.out_data !== 16'h8001) begin errors++; $display("FAIL flags_skid_out got=%h exp=8001", u_if.out_data); end
    checks++; if ({zr, ng} !== 2'b01) begin errors++; $display("FAIL flags_8001 got=%b%b exp=01", zr, ng); end
    tick();
    checks++; if (u_if.out_data !== 16'h7FFF) begin errors++; $display("FAIL flags_last_out got=%h exp=7fff", u_if.out_data); end
    checks++; if ({zr, ng} !== 2'b00) begin errors++; $display("FAIL flags_7fff got=%b%b exp=00", zr, ng); end
    u_if.in_valid = 1'b0;
    tick();
    u_if.out_ready = 1'b0;
  endtask
`endif

  initial begin
    u_if.in_valid = 1'b0;
    u_if.in_data = '0;
    u_if.out_ready = 1'b0;
    test_reset();
    test_back_to_back();
    test_skid();
`ifdef RESULT_SKID16_FLAGS_EN
    test_flags();
`endif
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
